d_ff_checker: RTL and testbench
===============================

// Module: d_ff_checker
// PURPOSE
//  Downstream consumer of the D flip-flop under test. Samples the flop's stimulus d and
//  its outputs q/q_o on the same clk, and checks each edge: q equals d one cycle late,
//  q_o equals ~d one cycle late, and both are 0 after reset. Keeps pass/error counts,
//  captures the first failure and flags q edges, so the bench or board reads one status.
// PARAMETERS
//  CNT_W        16  width of pass_cnt/err_cnt/tot counters
//  NUM_CHECKS   64  compares before DONE; 0 = never DONE (free-run)
//  STOP_ON_ERR  1   1: first mismatch -> HALT; 0: keep checking, count errors
// PORTS
//  clk       in   1      clock, shared with the flop under test
//  rst       in   1      synchronous reset, active-low, shared with the flop under test
//  d         in   1      stimulus driven into the flop's d
//  q         in   1      flop output q
//  q_o       in   1      flop output q_o
//  chk_en    in   1      1 = perform a compare this edge (RUN only)
//  clr       in   1      sync clear of counters/flags; returns DONE/HALT to RUN
//  state     out  2      00 IDLE, 01 RUN, 10 DONE, 11 HALT
//  pass_cnt  out  CNT_W  saturating count of matching compares
//  err_cnt   out  CNT_W  saturating count of mismatching compares
//  err       out  1      sticky: any error since reset/clr
//  err_code  out  3      first error: [0] q mismatch, [1] q_o mismatch, [2] bad reset value
//  q_rise    out  1      1-cycle pulse: q 0->1 seen (RUN only)
//  q_fall    out  1      1-cycle pulse: q 1->0 seen (RUN only)
//  done      out  1      high while state==DONE
// BEHAVIOUR
//  - All outputs registered. Edge with rst==0: state=IDLE, counters/tot=0, err=0,
//    err_code=0, q_rise=q_fall=done=0, d_dly=0, q_prev=0. Overrides clr and chk_en.
//  - d_dly<=d and q_prev<=q on every edge with rst==1, in every state.
//  - IDLE: first edge with rst==1 -> RUN. No compare. If q!=0 or q_o!=0 on that edge:
//    err=1, err_code=3'b100, err_cnt=1; -> HALT instead if STOP_ON_ERR=1.
//  - RUN, chk_en=1: exp_q=d_dly, exp_qo=~d_dly. Match -> pass_cnt+1; else err_cnt+1,
//    err=1, err_code={1'b0, q_o!=exp_qo, q!=exp_q} if err was 0 (first error held).
//    tot+1 per compare. Results visible after the same edge (latency 1 from sampling).
//  - RUN, chk_en=0: no compare; counters and flags hold; d_dly still tracks d.
//  - tot reaching NUM_CHECKS (NUM_CHECKS!=0) -> DONE on that edge; done=1.
//  - Mismatch with STOP_ON_ERR=1 -> HALT on that edge; HALT wins over DONE when both.
//  - DONE/HALT: no compares, counters frozen; leave only via clr or reset.
//  - clr=1 (rst==1): counters, tot, err, err_code cleared; DONE/HALT/RUN -> RUN; IDLE
//    unaffected. clr has priority over a same-edge compare (that compare is dropped).
//  - Counters saturate at {CNT_W{1'b1}}; tot saturates likewise (no wrap).
//  - q_rise = (q && !q_prev), q_fall = (!q && q_prev), only in RUN, else 0.
//  - Reset mid-RUN: flop and checker both reset same edge; restart at IDLE, no stale err.
// TESTING
//  1 rst=0 3 cycles, release, q=q_o=0 -> state IDLE->RUN, err=0, all counts 0.
//  2 d=1,0,1,0,... 8 cycles, chk_en=1, healthy flop -> pass_cnt=8, err_cnt=0, 4 q_rise.
//  3 force q_o=d_dly on 3rd compare, STOP_ON_ERR=1 -> err_code=3'b010, err_cnt=1, HALT.
//  4 CNT_W=4, NUM_CHECKS=0, 20 healthy compares -> pass_cnt=15 (saturated), state RUN.
//  5 NUM_CHECKS=5: 5 compares -> DONE, done=1; clr -> RUN, pass_cnt=0, done=0.
//  6 clr same edge as a forced mismatch -> err=0, err_cnt=0; rst low mid-RUN -> IDLE.

Source files
------------

// File: rtl/d_ff_checker.sv
// d_ff_checker: watches a D flip-flop under test on the shared clock.
// Each enabled edge checks that q == d and q_o == ~d from one cycle earlier.
// It also checks that the flop comes out of reset with both outputs low.
// Pass and error counts saturate, the first failure cause is held, and
// q edges are flagged, so a bench or board only has to read this status.
module d_ff_checker #(
  parameter int CNT_W       = 16,
  parameter int NUM_CHECKS  = 64,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             q,
  input  logic             q_o,
  input  logic             chk_en,
  input  logic             clr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             q_rise,
  output logic             q_fall,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    HALT = 2'b11
  } st_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  st_e              st, st_nx;
  logic [CNT_W-1:0] tot, tot_nx;
  logic [CNT_W-1:0] pass_nx, err_cnt_nx;
  logic             err_nx;
  logic [2:0]       code_nx;
  logic             d_dly, q_prev;
  logic             q_ok, qo_ok, mism;
  logic             hit_end;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // The flop should show last edge's d on q and its inverse on q_o.
  assign q_ok  = (q == d_dly);
  assign qo_ok = (q_o == ~d_dly);
  assign mism  = !(q_ok && qo_ok);

  // NUM_CHECKS == 0 means the checker never stops on its own.
  assign hit_end = (NUM_CHECKS != 0) && (int'(tot_nx) == NUM_CHECKS);

  // Next-state and next-count logic. clr beats a same-edge compare.
  always_comb begin
    st_nx      = st;
    tot_nx     = tot;
    pass_nx    = pass_cnt;
    err_cnt_nx = err_cnt;
    err_nx     = err;
    code_nx    = err_code;
    unique case (st)
      IDLE: begin
        // First edge out of reset: the only check is that the flop reset to 0/0.
        st_nx = RUN;
        if (q || q_o) begin
          err_nx     = 1'b1;
          code_nx    = 3'b100;
          err_cnt_nx = sat_inc(err_cnt);
          if (STOP_ON_ERR) st_nx = HALT;
        end
      end
      default: begin
        if (clr) begin
          st_nx      = RUN;
          tot_nx     = '0;
          pass_nx    = '0;
          err_cnt_nx = '0;
          err_nx     = 1'b0;
          code_nx    = 3'b000;
        end else if (st == RUN && chk_en) begin
          tot_nx = sat_inc(tot);
          if (mism) begin
            err_cnt_nx = sat_inc(err_cnt);
            err_nx     = 1'b1;
            // Only the first failure's cause is kept.
            if (!err) code_nx = {1'b0, !qo_ok, !q_ok};
          end else begin
            pass_nx = sat_inc(pass_cnt);
          end
          if (hit_end) st_nx = DONE;
          // A stopping error outranks reaching the check count.
          if (mism && STOP_ON_ERR) st_nx = HALT;
        end
      end
    endcase
  end

  // State, counters, flags and the delayed copies of d and q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= IDLE;
      tot      <= '0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      err      <= 1'b0;
      err_code <= 3'b000;
      q_rise   <= 1'b0;
      q_fall   <= 1'b0;
      done     <= 1'b0;
      d_dly    <= 1'b0;
      q_prev   <= 1'b0;
    end else begin
      st       <= st_nx;
      tot      <= tot_nx;
      pass_cnt <= pass_nx;
      err_cnt  <= err_cnt_nx;
      err      <= err_nx;
      err_code <= code_nx;
      q_rise   <= (st == RUN) && q && !q_prev;
      q_fall   <= (st == RUN) && !q && q_prev;
      done     <= (st_nx == DONE);
      d_dly    <= d;
      q_prev   <= q;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_d_ff_checker.sv
// Bench for d_ff_checker. A behavioural flop drives q/q_o, and faults can be
// XORed onto either output. Three checker instances share the stimulus:
// the default one, one with a 4-bit free-running counter, and one that is
// done after 5 checks. The expected status of the default instance is queued
// as each cycle is driven, then popped and compared once the edge has passed.
module tb_d_ff_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d = 1'b0, chk_en = 1'b0, clr = 1'b0;
  logic qf = 1'b0, qof = 1'b0;
  logic q_ff, qo_ff;
  logic q, q_o;

  always #5 clk = ~clk;

  // Flop under test: q follows d, q_o follows ~d, and both reset to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_ff  <= 1'b0;
      qo_ff <= 1'b0;
    end else begin
      q_ff  <= d;
      qo_ff <= ~d;
    end
  end
  assign q   = q_ff ^ qf;
  assign q_o = qo_ff ^ qof;

  logic [1:0]  s1_state, s4_state, s5_state;
  logic [15:0] s1_pass, s1_errc, s5_pass, s5_errc;
  logic [3:0]  s4_pass, s4_errc;
  logic        s1_err, s4_err, s5_err;
  logic [2:0]  s1_code, s4_code, s5_code;
  logic        s1_rise, s1_fall, s1_done;
  logic        s4_rise, s4_fall, s4_done;
  logic        s5_rise, s5_fall, s5_done;

  d_ff_checker #(.CNT_W(16), .NUM_CHECKS(64), .STOP_ON_ERR(1'b1)) u_dut (
    .clk(clk), .rst(rst), .d(d), .q(q), .q_o(q_o), .chk_en(chk_en), .clr(clr),
    .state(s1_state), .pass_cnt(s1_pass), .err_cnt(s1_errc), .err(s1_err),
    .err_code(s1_code), .q_rise(s1_rise), .q_fall(s1_fall), .done(s1_done));

  d_ff_checker #(.CNT_W(4), .NUM_CHECKS(0), .STOP_ON_ERR(1'b1)) u_sat (
    .clk(clk), .rst(rst), .d(d), .q(q), .q_o(q_o), .chk_en(chk_en), .clr(clr),
    .state(s4_state), .pass_cnt(s4_pass), .err_cnt(s4_errc), .err(s4_err),
    .err_code(s4_code), .q_rise(s4_rise), .q_fall(s4_fall), .done(s4_done));

  d_ff_checker #(.CNT_W(16), .NUM_CHECKS(5), .STOP_ON_ERR(1'b1)) u_done (
    .clk(clk), .rst(rst), .d(d), .q(q), .q_o(q_o), .chk_en(chk_en), .clr(clr),
    .state(s5_state), .pass_cnt(s5_pass), .err_cnt(s5_errc), .err(s5_err),
    .err_code(s5_code), .q_rise(s5_rise), .q_fall(s5_fall), .done(s5_done));

  typedef struct {
    logic [1:0] st;
    int         pass;
    int         errc;
    logic       err;
    logic [2:0] code;
    logic       edges;
    logic       rise;
    logic       fall;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_rise = 0;

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic exp_t ex(input logic [1:0] s, input int p, input int ec,
                              input logic er, input logic [2:0] cd);
    exp_t e;
    e.st = s; e.pass = p; e.errc = ec; e.err = er; e.code = cd;
    e.edges = 1'b0; e.rise = 1'b0; e.fall = 1'b0;
    return e;
  endfunction

  // Pop the oldest expectation and compare it with the default instance.
  task automatic sb_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk("state", int'(s1_state), int'(e.st));
    chk("pass_cnt", int'(s1_pass), e.pass);
    chk("err_cnt", int'(s1_errc), e.errc);
    chk("err", int'(s1_err), int'(e.err));
    chk("err_code", int'(s1_code), int'(e.code));
    chk("done", int'(s1_done), int'(e.st == 2'b10));
    if (e.edges) begin
      chk("q_rise", int'(s1_rise), int'(e.rise));
      chk("q_fall", int'(s1_fall), int'(e.fall));
    end
  endtask

  // Drive one cycle, queue what it should produce, then check after the edge.
  task automatic step(input logic rr, input logic dd, input logic en,
                      input logic cl, input logic fq, input logic fqo,
                      input exp_t e);
    rst = rr; d = dd; chk_en = en; clr = cl; qf = fq; qof = fqo;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    sb_pop();
    qf = 1'b0; qof = 1'b0; clr = 1'b0;
  endtask

  // Two reset edges, then the release edge that moves the checker to RUN.
  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 0, 0, 1'b0, 3'b000));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 0, 0, 1'b0, 3'b000));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 0, 0, 1'b0, 3'b000));
  endtask

  initial begin
    exp_t e;
    // 1: reset and release.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 0, 0, 1'b0, 3'b000));
    do_reset();

    // 2: alternating d with a healthy flop. q rises on even cycles.
    for (int i = 1; i <= 8; i++) begin
      e = ex(2'b01, i, 0, 1'b0, 3'b000);
      e.edges = 1'b1;
      e.rise  = (i % 2 == 0);
      e.fall  = (i % 2 == 1) && (i > 1);
      step(1'b1, logic'(i % 2), 1'b1, 1'b0, 1'b0, 1'b0, e);
      if (s1_rise) n_rise++;
    end
    chk("rise_total", n_rise, 4);
    // With chk_en low the counters hold, but edge flags still track q.
    e = ex(2'b01, 8, 0, 1'b0, 3'b000);
    e.edges = 1'b1; e.rise = 1'b0; e.fall = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);

    // 3: q_o fault on the third compare halts with only the q_o bit set.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ex(2'b01, 1, 0, 1'b0, 3'b000));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(2'b01, 2, 0, 1'b0, 3'b000));
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ex(2'b11, 2, 1, 1'b1, 3'b010));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(2'b11, 2, 1, 1'b1, 3'b010));
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(2'b01, 0, 0, 1'b0, 3'b000));

    // 4: 20 healthy compares saturate the 4-bit counter at 15.
    do_reset();
    for (int i = 1; i <= 20; i++)
      step(1'b1, logic'((i / 3) % 2), 1'b1, 1'b0, 1'b0, 1'b0,
           ex(2'b01, i, 0, 1'b0, 3'b000));
    chk("sat_pass", int'(s4_pass), 15);
    chk("sat_state", int'(s4_state), 1);
    chk("sat_errc", int'(s4_errc), 0);

    // 5: the five-check instance reaches DONE, then clr returns it to RUN.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, logic'(i % 2), 1'b1, 1'b0, 1'b0, 1'b0,
           ex(2'b01, i, 0, 1'b0, 3'b000));
      if (i == 4) begin
        chk("done5_early", int'(s5_done), 0);
        chk("state5_early", int'(s5_state), 1);
      end
    end
    chk("state5_done", int'(s5_state), 2);
    chk("done5", int'(s5_done), 1);
    chk("pass5", int'(s5_pass), 5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 5, 0, 1'b0, 3'b000));
    chk("pass5_frozen", int'(s5_pass), 5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(2'b01, 0, 0, 1'b0, 3'b000));
    chk("state5_clr", int'(s5_state), 1);
    chk("pass5_clr", int'(s5_pass), 0);
    chk("done5_clr", int'(s5_done), 0);

    // 6: clr drops a same-edge mismatch, then a reset mid-RUN returns to IDLE.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ex(2'b01, 1, 0, 1'b0, 3'b000));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(2'b01, 2, 0, 1'b0, 3'b000));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ex(2'b01, 0, 0, 1'b0, 3'b000));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(2'b01, 1, 0, 1'b0, 3'b000));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ex(2'b00, 0, 0, 1'b0, 3'b000));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 0, 0, 1'b0, 3'b000));

    // q stuck high coming out of reset is a bad reset value and halts.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 0, 0, 1'b0, 3'b000));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex(2'b11, 0, 1, 1'b1, 3'b100));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
